dac_write_scheduler: RTL and testbench

- Upstream stage of the multi-slave SPI DAC controller.
- Accepts single-word host writes addressed to a DAC slave and drives that controller's per-slave `new_reg` pulse and `spi_data` word.
- Keeps each slave's `spi_data` stable from request until that slave's transfer completes; completion is detected by monitoring that slave's `bCS` line.
- Coalesces writes that arrive while a slave is busy, and flags slaves that never respond.

---
 rtl/dac_write_scheduler.sv | 163 ++++++++++++++++
 tb/tb_dac_write_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_write_scheduler.sv
// Per-slave write scheduler for a multi-slave SPI DAC controller: holds each slave's word
// stable for the whole transfer, queues one word per busy slave, and aborts slaves that stall.
module dac_write_scheduler #(
    parameter int unsigned spi_slaves   = 2,
    parameter int unsigned spi_length   = 16,
    parameter int unsigned busy_timeout = 8192,
    localparam int unsigned addr_w = (spi_slaves > 1) ? $clog2(spi_slaves) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_valid,
    input  logic [addr_w-1:0]                wr_addr,
    input  logic [spi_length-1:0]            wr_data,
    input  logic [spi_slaves-1:0]            bCS_mon,
    input  logic                             err_clr,
    output logic [spi_slaves-1:0]            new_reg,
    output logic [spi_slaves*spi_length-1:0] spi_data,
    output logic [spi_slaves-1:0]            busy,
    output logic [spi_slaves-1:0]            pending,
    output logic [spi_slaves-1:0]            timeout_err,
    output logic                             addr_err,
    output logic [15:0]                      coalesce_cnt
);

    localparam int unsigned CntW = $clog2(busy_timeout + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(busy_timeout - 1);
    localparam logic [addr_w:0] SlavesW = (addr_w + 1)'(spi_slaves);

    typedef enum logic [2:0] {StIdle, StIssue, StWaitStart, StWaitEnd, StDone} state_e;

    state_e                state_q     [spi_slaves];
    state_e                state_d     [spi_slaves];
    logic [CntW-1:0]       cnt_q       [spi_slaves];
    logic [CntW-1:0]       cnt_d       [spi_slaves];
    logic [spi_length-1:0] active_q    [spi_slaves];
    logic [spi_length-1:0] active_d    [spi_slaves];
    logic [spi_length-1:0] pend_data_q [spi_slaves];
    logic [spi_length-1:0] pend_data_d [spi_slaves];
    logic [spi_slaves-1:0] pend_flag_q, pend_flag_d;
    logic [spi_slaves-1:0] tmo_q, tmo_d;
    logic                  addr_err_q, addr_err_d;
    logic [15:0]           coal_q, coal_d;

    logic                  addr_bad;
    logic [spi_slaves-1:0] wr_hit;
    logic [spi_slaves-1:0] tmo_set;
    logic                  coal_inc;

    always_comb begin
        addr_bad = wr_valid && ({1'b0, wr_addr} >= SlavesW);
        for (int k = 0; k < spi_slaves; k++) begin
            wr_hit[k] = wr_valid && !addr_bad && (wr_addr == addr_w'(k));
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        active_d    = active_q;
        pend_data_d = pend_data_q;
        pend_flag_d = pend_flag_q;
        tmo_set     = '0;
        coal_inc    = 1'b0;
        new_reg     = '0;
        busy        = '0;
        for (int k = 0; k < spi_slaves; k++) begin
            busy[k] = (state_q[k] != StIdle);
            unique case (state_q[k])
                // A write in IDLE or DONE goes straight to active, discarding any queued word.
                StIdle, StDone: begin
                    if (wr_hit[k]) begin
                        active_d[k] = wr_data;
                        state_d[k]  = StIssue;
                        if (pend_flag_q[k]) begin
                            pend_flag_d[k] = 1'b0;
                            coal_inc       = 1'b1;
                        end
                    end else if (pend_flag_q[k]) begin
                        active_d[k]    = pend_data_q[k];
                        pend_flag_d[k] = 1'b0;
                        state_d[k]     = StIssue;
                    end else begin
                        state_d[k] = StIdle;
                    end
                end
                StIssue: begin
                    new_reg[k] = 1'b1;
                    cnt_d[k]   = '0;
                    state_d[k] = StWaitStart;
                end
                StWaitStart: begin
                    if (!bCS_mon[k]) begin
                        cnt_d[k]   = '0;
                        state_d[k] = StWaitEnd;
                    end else if (cnt_q[k] == CntLast) begin
                        tmo_set[k] = 1'b1;
                        state_d[k] = StIdle;
                    end else begin
                        cnt_d[k] = cnt_q[k] + CntW'(1);
                    end
                end
                StWaitEnd: begin
                    if (bCS_mon[k]) begin
                        state_d[k] = StDone;
                    end else if (cnt_q[k] == CntLast) begin
                        tmo_set[k] = 1'b1;
                        state_d[k] = StIdle;
                    end else begin
                        cnt_d[k] = cnt_q[k] + CntW'(1);
                    end
                end
                default: state_d[k] = StIdle;
            endcase
            if (wr_hit[k] && (state_q[k] inside {StIssue, StWaitStart, StWaitEnd})) begin
                pend_data_d[k] = wr_data;
                pend_flag_d[k] = 1'b1;
                if (pend_flag_q[k]) coal_inc = 1'b1;
            end
        end
        tmo_d      = (tmo_q & ~{spi_slaves{err_clr}}) | tmo_set;
        addr_err_d = (addr_err_q && !err_clr) || addr_bad;
        coal_d     = (coal_inc && (coal_q != 16'hFFFF)) ? coal_q + 16'd1 : coal_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < spi_slaves; k++) begin
                state_q[k]     <= StIdle;
                cnt_q[k]       <= '0;
                active_q[k]    <= '0;
                pend_data_q[k] <= '0;
            end
            pend_flag_q <= '0;
            tmo_q       <= '0;
            addr_err_q  <= 1'b0;
            coal_q      <= '0;
        end else begin
            for (int k = 0; k < spi_slaves; k++) begin
                state_q[k]     <= state_d[k];
                cnt_q[k]       <= cnt_d[k];
                active_q[k]    <= active_d[k];
                pend_data_q[k] <= pend_data_d[k];
            end
            pend_flag_q <= pend_flag_d;
            tmo_q       <= tmo_d;
            addr_err_q  <= addr_err_d;
            coal_q      <= coal_d;
        end
    end

    always_comb begin
        spi_data = '0;
        for (int k = 0; k < spi_slaves; k++) begin
            spi_data[k*spi_length +: spi_length] = active_q[k];
        end
    end

    assign pending      = pend_flag_q;
    assign timeout_err  = tmo_q;
    assign addr_err     = addr_err_q;
    assign coalesce_cnt = coal_q;

endmodule

// File: tb/tb_dac_write_scheduler.sv
// Scoreboard bench for dac_write_scheduler: directed scenarios then randomized writes and
// chip-select responses, checked against a transaction-level reference model.
module tb_dac_write_scheduler;

    localparam int S   = 3;
    localparam int L   = 16;
    localparam int TMO = 16;

    logic           clk;
    logic           rst;
    logic           wr_valid;
    logic [1:0]     wr_addr;
    logic [L-1:0]   wr_data;
    logic [S-1:0]   bcs;
    logic           err_clr;
    logic [S-1:0]   new_reg;
    logic [S*L-1:0] spi_data;
    logic [S-1:0]   busy;
    logic [S-1:0]   pending;
    logic [S-1:0]   timeout_err;
    logic           addr_err;
    logic [15:0]    coalesce_cnt;

    dac_write_scheduler #(
        .spi_slaves  (S),
        .spi_length  (L),
        .busy_timeout(TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .bCS_mon     (bcs),
        .err_clr     (err_clr),
        .new_reg     (new_reg),
        .spi_data    (spi_data),
        .busy        (busy),
        .pending     (pending),
        .timeout_err (timeout_err),
        .addr_err    (addr_err),
        .coalesce_cnt(coalesce_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each slave is either free, announcing a word, waiting for its CS to
    // fall, waiting for it to rise, or finishing; one queued word may wait behind it.
    typedef enum int {MFree, MReq, MLow, MHigh, MFin} mstage_e;
    typedef struct {
        int           cyc;
        logic [L-1:0] w;
    } exp_t;

    mstage_e      m_st    [S];
    int           m_el    [S];
    logic [L-1:0] m_act   [S];
    logic [L-1:0] m_pdata [S];
    bit           m_pflag [S];
    bit           m_tmo   [S];
    bit           m_aerr;
    int           m_coal;
    int           cyc = 0;
    exp_t         exp_q   [S][$];
    bit           mon_en = 0;

    task automatic model_reset();
        for (int k = 0; k < S; k++) begin
            m_st[k] = MFree; m_el[k] = 0; m_act[k] = '0; m_pdata[k] = '0;
            m_pflag[k] = 0; m_tmo[k] = 0;
            exp_q[k].delete();
        end
        m_aerr = 0;
        m_coal = 0;
    endtask

    task automatic model_step();
        bit bad, any_coal;
        cyc++;
        if (!rst) begin
            model_reset();
            return;
        end
        bad = wr_valid && (int'(wr_addr) >= S);
        any_coal = 0;
        for (int k = 0; k < S; k++) begin
            bit hit, tset, was_pend;
            hit = wr_valid && !bad && (int'(wr_addr) == k);
            tset = 0;
            was_pend = m_pflag[k];
            if (m_st[k] == MFree || m_st[k] == MFin) begin
                if (hit) begin
                    m_act[k] = wr_data;
                    if (was_pend) any_coal = 1;
                    m_pflag[k] = 0;
                    m_st[k] = MReq;
                end else if (was_pend) begin
                    m_act[k] = m_pdata[k];
                    m_pflag[k] = 0;
                    m_st[k] = MReq;
                end else begin
                    m_st[k] = MFree;
                end
            end else begin
                if (hit) begin
                    m_pdata[k] = wr_data;
                    m_pflag[k] = 1;
                    if (was_pend) any_coal = 1;
                end
                if (m_st[k] == MReq) begin
                    m_st[k] = MLow; m_el[k] = 0;
                end else if ((m_st[k] == MLow && !bcs[k]) || (m_st[k] == MHigh && bcs[k])) begin
                    m_st[k] = (m_st[k] == MLow) ? MHigh : MFin;
                    m_el[k] = 0;
                end else if (m_el[k] + 1 == TMO) begin
                    tset = 1;
                    m_st[k] = MFree;
                end else begin
                    m_el[k]++;
                end
            end
            if (m_st[k] == MReq) exp_q[k].push_back('{cyc, m_act[k]});
            m_tmo[k] = (m_tmo[k] && !err_clr) || tset;
        end
        m_aerr = (m_aerr && !err_clr) || bad;
        if (any_coal && m_coal < 65535) m_coal++;
    endtask

    // Monitor: pops an expected word whenever the DUT pulses new_reg, checks state outputs.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [S*L-1:0] e_data;
            logic [S-1:0]   e_busy, e_pend, e_tmo;
            for (int k = 0; k < S; k++) begin
                while (exp_q[k].size() > 0 && exp_q[k][0].cyc < cyc) begin
                    chk($sformatf("missed_new_reg[%0d]", k), 64'd0, 64'd1);
                    void'(exp_q[k].pop_front());
                end
                if (new_reg[k]) begin
                    if (exp_q[k].size() == 0) begin
                        chk($sformatf("unexpected_new_reg[%0d]", k), 64'd1, 64'd0);
                    end else begin
                        exp_t e;
                        e = exp_q[k].pop_front();
                        chk($sformatf("issue_word[%0d]", k), 64'(spi_data[k*L +: L]),
                            64'(e.w));
                    end
                end
                e_data[k*L +: L] = m_act[k];
                e_busy[k] = (m_st[k] != MFree);
                e_pend[k] = m_pflag[k];
                e_tmo[k]  = m_tmo[k];
            end
            chk("spi_data", 64'(spi_data), 64'(e_data));
            chk("busy", 64'(busy), 64'(e_busy));
            chk("pending", 64'(pending), 64'(e_pend));
            chk("timeout_err", 64'(timeout_err), 64'(e_tmo));
            chk("addr_err", 64'(addr_err), 64'(m_aerr));
            chk("coalesce_cnt", 64'(coalesce_cnt), 64'(m_coal));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic wr(input int a, input logic [L-1:0] d);
        wr_valid = 1'b1;
        wr_addr  = 2'(a);
        wr_data  = d;
    endtask

    int rs [S];
    int rc [S];
    int rl [S];

    initial begin
        rst = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; bcs = '1; err_clr = 1'b0;
        model_reset();
        repeat (3) tick();
        rst = 1'b1;
        mon_en = 1;
        chk("rst_new_reg", 64'(new_reg), 64'd0);
        chk("rst_spi_data", 64'(spi_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_coal", 64'(coalesce_cnt), 64'd0);

        // Single write to slave 1, then a 10-cycle transfer.
        wr(1, 16'hA5C3); tick(); wr_valid = 1'b0;
        chk("wr1_new_reg", 64'(new_reg), 64'b010);
        chk("wr1_data", 64'(spi_data[31:16]), 64'hA5C3);
        tick();
        chk("wr1_pulse_once", 64'(new_reg), 64'd0);
        bcs[1] = 1'b0; repeat (10) tick();
        bcs[1] = 1'b1; tick();
        chk("wr1_busy_done", 64'(busy[1]), 64'd1);
        tick();
        chk("wr1_busy_idle", 64'(busy[1]), 64'd0);

        // Coalescing on slave 0.
        wr(0, 16'h0001); tick(); wr_valid = 1'b0;
        chk("co_new_reg", 64'(new_reg), 64'b001);
        bcs[0] = 1'b0; tick(); tick();
        wr(0, 16'h0002); tick();
        wr(0, 16'h0003); tick(); wr_valid = 1'b0;
        chk("co_cnt", 64'(coalesce_cnt), 64'd1);
        chk("co_pending", 64'(pending[0]), 64'd1);
        chk("co_hold", 64'(spi_data[15:0]), 64'h0001);
        bcs[0] = 1'b1; tick();
        chk("co_done_hold", 64'(spi_data[15:0]), 64'h0001);
        tick();
        chk("co_reissue", 64'(new_reg), 64'b001);
        chk("co_reissue_data", 64'(spi_data[15:0]), 64'h0003);

        // Write landing on the DONE cycle bypasses the queued word.
        bcs[0] = 1'b0; tick(); tick();
        wr(0, 16'h1111); tick(); wr_valid = 1'b0;
        bcs[0] = 1'b1; tick();
        wr(0, 16'h2222); tick(); wr_valid = 1'b0;
        chk("byp_data", 64'(spi_data[15:0]), 64'h2222);
        chk("byp_new_reg", 64'(new_reg), 64'b001);
        chk("byp_cnt", 64'(coalesce_cnt), 64'd2);
        chk("byp_pending", 64'(pending[0]), 64'd0);
        bcs[0] = 1'b0; tick(); tick();
        bcs[0] = 1'b1; tick(); tick();
        chk("byp_idle", 64'(busy[0]), 64'd0);

        // Timeout with CS never falling.
        wr(0, 16'hBEEF); tick(); wr_valid = 1'b0;
        chk("tmo_issue", 64'(new_reg), 64'b001);
        repeat (16) tick();
        chk("tmo_not_yet", 64'(timeout_err), 64'd0);
        chk("tmo_busy", 64'(busy[0]), 64'd1);
        tick();
        chk("tmo_set", 64'(timeout_err), 64'b001);
        chk("tmo_idle", 64'(busy[0]), 64'd0);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("tmo_clr", 64'(timeout_err), 64'd0);

        // Out-of-range address.
        wr(3, 16'h7777); tick(); wr_valid = 1'b0;
        chk("aerr_no_req", 64'(new_reg), 64'd0);
        chk("aerr_flag", 64'(addr_err), 64'd1);
        chk("aerr_data", 64'(spi_data), 64'h0000_A5C3_BEEF);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("aerr_clr", 64'(addr_err), 64'd0);

        // Reset while slave 1 is mid-transfer with a queued word.
        wr(1, 16'h1234); tick(); wr_valid = 1'b0;
        bcs[1] = 1'b0; tick(); tick();
        wr(1, 16'h5678); tick(); wr_valid = 1'b0;
        chk("mid_pending", 64'(pending), 64'b010);
        #2;
        rst = 1'b0; mon_en = 0; model_reset();
        #1;
        chk("arst_new_reg", 64'(new_reg), 64'd0);
        chk("arst_spi_data", 64'(spi_data), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_pending", 64'(pending), 64'd0);
        chk("arst_coal", 64'(coalesce_cnt), 64'd0);
        bcs[1] = 1'b1;
        tick(); tick();
        rst = 1'b1; mon_en = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_quiet", 64'(new_reg), 64'd0);
        end

        // Randomized traffic with a responding SPI controller.
        for (int k = 0; k < S; k++) begin rs[k] = 0; rc[k] = 0; rl[k] = 0; end
        for (int c = 0; c < 2500; c++) begin
            for (int k = 0; k < S; k++) begin
                if (new_reg[k]) begin
                    int r;
                    r = $urandom_range(0, 9);
                    rs[k] = 1;
                    rc[k] = (r == 0) ? 30 : $urandom_range(0, 6);
                    rl[k] = (r == 1) ? 25 : $urandom_range(1, 8);
                end else if (rs[k] == 1) begin
                    if (rc[k] == 0) begin bcs[k] = 1'b0; rs[k] = 2; rc[k] = rl[k]; end
                    else rc[k]--;
                end else if (rs[k] == 2) begin
                    if (rc[k] == 0) begin bcs[k] = 1'b1; rs[k] = 0; end
                    else rc[k]--;
                end
            end
            if (c < 2350) begin
                wr_valid = ($urandom_range(0, 99) < 35);
                wr_addr  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                wr_data  = L'($urandom);
                err_clr  = ($urandom_range(0, 31) == 0);
            end else begin
                wr_valid = 1'b0;
                err_clr  = 1'b0;
            end
            tick();
        end
        for (int k = 0; k < S; k++) begin
            chk($sformatf("drain_q[%0d]", k), 64'(exp_q[k].size()), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
